daq_evttag_queue: RTL and testbench

- Generates the event tag consumed by the DAQ buffer/DMA stage and queues one tag per L1A.
- The tag is built from free-running bunch-crossing, spill, time-in-spill and event counters.
- The head-of-queue tag drives the downstream evttag[87:0] input; the downstream tagdone pulse pops it.
- Lives entirely in the bx_clk domain, with busy back-pressure to the trigger logic.

---
 rtl/daq_evttag_queue_if.sv | 28 ++
 rtl/daq_evttag_queue.sv | 143 ++++++++++++++
 tb/tb_daq_evttag_queue.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/daq_evttag_queue_if.sv
// Trigger/downstream-facing signal bundle of the event-tag queue.
// master = trigger + DMA side driving pulses; slave = the queue itself.
interface daq_evttag_queue_if #(
    parameter int DEPTH = 16
) ();
    localparam int OW = $clog2(DEPTH) + 1;

    logic           clear;
    logic           l1a;
    logic           spill_start;
    logic           tagdone;
    logic [87:0]    evttag;
    logic           evttag_valid;
    logic [OW-1:0]  occupancy;
    logic           busy;
    logic [15:0]    drop_count;
    logic [7:0]     underflow_count;

    modport master (
        output clear, l1a, spill_start, tagdone,
        input  evttag, evttag_valid, occupancy, busy, drop_count, underflow_count
    );

    modport slave (
        input  clear, l1a, spill_start, tagdone,
        output evttag, evttag_valid, occupancy, busy, drop_count, underflow_count
    );
endinterface

// File: rtl/daq_evttag_queue.sv
// Builds {evtid, time_in_spill, spill, bxid} tags and queues one per L1A; head tag is
// registered (valid 2 cycles after l1a); busy at BUSY_THRESH, L1As dropped when full.
module daq_evttag_queue #(
    parameter int          DEPTH       = 16,
    parameter logic [11:0] BXID_MAX    = 12'hFFF,
    parameter int          BUSY_THRESH = 14
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    daq_evttag_queue_if.slave    q_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [11:0]    r_bxid;
    logic [11:0]    r_spill;
    logic [31:0]    r_tis;
    logic [31:0]    r_evtid;

    logic [87:0]    r_mem [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [PW-1:0]  r_occ;
    logic           r_busy;
    logic [87:0]    r_evttag;
    logic           r_evttag_vld;
    logic [15:0]    r_drop;
    logic [7:0]     r_uf;

    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_drop;
    logic           w_underflow;
    logic [87:0]    w_tag;
    logic [PW-1:0]  w_occ_nxt;

    assign w_tag   = {r_evtid, r_tis, r_spill, r_bxid};
    assign w_full  = (r_occ == PW'(DEPTH));
    assign w_empty = (r_occ == '0);

    // An L1A meeting a tagdone on an empty queue passes straight through:
    // it counts as both a push and a pop, not as an underflow.
    assign w_push      = q_if.l1a && (!w_full || q_if.tagdone);
    assign w_pop       = q_if.tagdone && (!w_empty || w_push);
    assign w_drop      = q_if.l1a && !w_push;
    assign w_underflow = q_if.tagdone && !w_pop;

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_push && !w_pop) begin
            w_occ_nxt = r_occ + PW'(1);
        end else if (w_pop && !w_push) begin
            w_occ_nxt = r_occ - PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bxid  <= '0;
            r_spill <= '0;
            r_tis   <= '0;
            r_evtid <= '0;
        end else if (q_if.clear) begin
            r_bxid  <= '0;
            r_spill <= '0;
            r_tis   <= '0;
            r_evtid <= '0;
        end else begin
            r_bxid <= (r_bxid == BXID_MAX) ? 12'd0 : r_bxid + 12'd1;
            if (q_if.spill_start) begin
                r_spill <= r_spill + 12'd1;
                r_tis   <= '0;
            end else if (r_tis != 32'hFFFF_FFFF) begin
                r_tis <= r_tis + 32'd1;
            end
            // Dropped triggers still consume an evtid so downstream sees the gap.
            if (q_if.l1a) begin
                r_evtid <= r_evtid + 32'd1;
            end
        end
    end

    // Storage is wiped on reset too, so no stale tag can reappear afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!q_if.clear && w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_tag;
        end
    end

    // The head is read from the array a cycle after any write lands, so a tag
    // written into the head slot is always seen with its new contents.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_occ        <= '0;
            r_busy       <= 1'b0;
            r_evttag     <= '0;
            r_evttag_vld <= 1'b0;
            r_drop       <= '0;
            r_uf         <= '0;
        end else if (q_if.clear) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_occ        <= '0;
            r_busy       <= 1'b0;
            r_evttag     <= '0;
            r_evttag_vld <= 1'b0;
            r_drop       <= '0;
            r_uf         <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_occ        <= w_occ_nxt;
            r_busy       <= (w_occ_nxt >= PW'(BUSY_THRESH));
            r_evttag_vld <= !w_empty;
            r_evttag     <= w_empty ? 88'd0 : r_mem[r_rptr[AW-1:0]];
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
            if (w_underflow && (r_uf != 8'hFF)) begin
                r_uf <= r_uf + 8'd1;
            end
        end
    end

    assign q_if.evttag          = r_evttag;
    assign q_if.evttag_valid    = r_evttag_vld;
    assign q_if.occupancy       = r_occ;
    assign q_if.busy            = r_busy;
    assign q_if.drop_count      = r_drop;
    assign q_if.underflow_count = r_uf;
endmodule

// File: tb/tb_daq_evttag_queue.sv
// Bench for daq_evttag_queue: scoreboard model of counters/queue checked every cycle,
// an occupancy/flag vector table, and hand sequences for tag fields, wrap and reset.
module tb_daq_evttag_queue;
    localparam int          DEPTH = 16;
    localparam logic [11:0] BXMAX = 12'd3563;
    localparam int          THR   = 14;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    daq_evttag_queue_if #(.DEPTH(DEPTH)) bus ();

    daq_evttag_queue #(
        .DEPTH      (DEPTH),
        .BXID_MAX   (BXMAX),
        .BUSY_THRESH(THR)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .q_if   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit g_chk  = 1'b1;

    logic [11:0] m_bx, m_sp;
    logic [31:0] m_tis, m_ev;
    logic [87:0] q[$];
    logic [87:0] m_out;
    logic        m_vld;
    logic [15:0] m_drop;
    logic [7:0]  m_uf;

    typedef struct {
        bit          clr;
        bit          l1a;
        bit          td;
        logic [4:0]  occ;
        logic        busy;
        logic [15:0] drop;
        logic [7:0]  uf;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_zero();
        m_bx = '0; m_sp = '0; m_tis = '0; m_ev = '0;
        q.delete();
        m_out = '0; m_vld = 1'b0; m_drop = '0; m_uf = '0;
    endtask

    function automatic vec_t mk(bit c, bit l, bit t, logic [4:0] o, logic b, logic [15:0] d, logic [7:0] u);
        vec_t v;
        v.clr = c; v.l1a = l; v.td = t; v.occ = o; v.busy = b; v.drop = d; v.uf = u;
        return v;
    endfunction

    // Drive one cycle; the model advances by exactly what the DUT should do at this edge.
    task automatic cyc(input bit l, input bit s, input bit t, input bit c);
        logic [87:0] tag;
        bit full, push, pop;
        bus.l1a = l; bus.spill_start = s; bus.tagdone = t; bus.clear = c;
        if (c) begin
            model_zero();
        end else begin
            m_vld = (q.size() != 0);
            m_out = m_vld ? q[0] : '0;
            tag   = {m_ev, m_tis, m_sp, m_bx};
            full  = (q.size() == DEPTH);
            push  = l && (!full || t);
            pop   = t && ((q.size() != 0) || push);
            if (push) q.push_back(tag);
            if (pop) void'(q.pop_front());
            if (l && !push && m_drop != 16'hFFFF) m_drop++;
            if (t && !pop && m_uf != 8'hFF) m_uf++;
            m_bx = (m_bx == BXMAX) ? 12'd0 : m_bx + 12'd1;
            if (s) begin m_sp = m_sp + 12'd1; m_tis = '0; end
            else if (m_tis != 32'hFFFF_FFFF) m_tis = m_tis + 32'd1;
            if (l) m_ev = m_ev + 32'd1;
        end
        @(posedge clk); #1;
        bus.l1a = 1'b0; bus.spill_start = 1'b0; bus.tagdone = 1'b0; bus.clear = 1'b0;
        if (g_chk) begin
            check("evttag", bus.evttag, m_out);
            check("evttag_valid", 88'(bus.evttag_valid), 88'(m_vld));
            check("occupancy", 88'(bus.occupancy), 88'(q.size()));
            check("busy", 88'(bus.busy), 88'(q.size() >= THR));
            check("drop_count", 88'(bus.drop_count), 88'(m_drop));
            check("underflow_count", 88'(bus.underflow_count), 88'(m_uf));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_evttag"}, bus.evttag, 88'd0);
        check({tag, "_valid"}, 88'(bus.evttag_valid), 88'd0);
        check({tag, "_occ"}, 88'(bus.occupancy), 88'd0);
        check({tag, "_busy"}, 88'(bus.busy), 88'd0);
        check({tag, "_drop"}, 88'(bus.drop_count), 88'd0);
        check({tag, "_uf"}, 88'(bus.underflow_count), 88'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] exp_bx;

        // Vectors: empty-queue underflow, fill/drop/refill, then full with push+pop.
        tbl.push_back(mk(1, 0, 0, 5'd0, 0, 16'd0, 8'd0));
        tbl.push_back(mk(0, 0, 1, 5'd0, 0, 16'd0, 8'd1));
        tbl.push_back(mk(0, 0, 1, 5'd0, 0, 16'd0, 8'd2));
        tbl.push_back(mk(0, 0, 1, 5'd0, 0, 16'd0, 8'd3));
        tbl.push_back(mk(0, 1, 1, 5'd0, 0, 16'd0, 8'd3));
        tbl.push_back(mk(1, 0, 0, 5'd0, 0, 16'd0, 8'd0));
        for (int k = 1; k <= 16; k++) tbl.push_back(mk(0, 1, 0, 5'(k), k >= 14, 16'd0, 8'd0));
        tbl.push_back(mk(0, 1, 0, 5'd16, 1, 16'd1, 8'd0));
        tbl.push_back(mk(0, 0, 1, 5'd15, 1, 16'd1, 8'd0));
        tbl.push_back(mk(0, 0, 1, 5'd14, 1, 16'd1, 8'd0));
        tbl.push_back(mk(0, 0, 1, 5'd13, 0, 16'd1, 8'd0));
        tbl.push_back(mk(1, 0, 0, 5'd0, 0, 16'd0, 8'd0));
        for (int k = 1; k <= 16; k++) tbl.push_back(mk(0, 1, 0, 5'(k), k >= 14, 16'd0, 8'd0));
        tbl.push_back(mk(0, 1, 1, 5'd16, 1, 16'd0, 8'd0));

        rst_n = 1'b0;
        bus.clear = 1'b0; bus.l1a = 1'b0; bus.spill_start = 1'b0; bus.tagdone = 1'b0;
        model_zero();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // First L1A at cycle 20 after reset.
        repeat (19) cyc(0, 0, 0, 0);
        exp_bx = m_bx;
        cyc(1, 0, 0, 0);
        check("t1_valid_early", 88'(bus.evttag_valid), 88'd0);
        cyc(0, 0, 0, 0);
        check("t1_valid", 88'(bus.evttag_valid), 88'd1);
        check("t1_bxid", 88'(bus.evttag[11:0]), 88'(exp_bx));
        check("t1_evtid", 88'(bus.evttag[87:56]), 88'd0);
        check("t1_spill", 88'(bus.evttag[23:12]), 88'd0);
        check("t1_occ", 88'(bus.occupancy), 88'd1);

        // Spill fields, including spill_start coinciding with l1a.
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        check("t2_spill", 88'(bus.evttag[23:12]), 88'd1);
        check("t2_tis", 88'(bus.evttag[55:24]), 88'd4);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        check("t2_coinc_spill", 88'(bus.evttag[23:12]), 88'd1);
        check("t2_coinc_tis", 88'(bus.evttag[55:24]), 88'd5);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].l1a, 1'b0, tbl[i].td, tbl[i].clr);
            check($sformatf("tbl%0d_occ", i), 88'(bus.occupancy), 88'(tbl[i].occ));
            check($sformatf("tbl%0d_busy", i), 88'(bus.busy), 88'(tbl[i].busy));
            check($sformatf("tbl%0d_drop", i), 88'(bus.drop_count), 88'(tbl[i].drop));
            check($sformatf("tbl%0d_uf", i), 88'(bus.underflow_count), 88'(tbl[i].uf));
        end
        cyc(0, 0, 0, 0);
        check("t4_head_evtid", 88'(bus.evttag[87:56]), 88'd1);

        // After a drop, the next accepted tag shows the evtid gap.
        cyc(0, 0, 0, 1);
        repeat (16) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        repeat (15) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        check("t3_tail_evtid", 88'(bus.evttag[87:56]), 88'd17);
        check("t3_tail_occ", 88'(bus.occupancy), 88'd1);

        // bxid wrap at BXMAX.
        cyc(0, 0, 0, 1);
        g_chk = 1'b0;
        for (int i = 0; i < 4000 && m_bx != BXMAX; i++) cyc(0, 0, 0, 0);
        g_chk = 1'b1;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("t6_bx_last", 88'(bus.evttag[11:0]), 88'(BXMAX));
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        check("t6_bx_wrap", 88'(bus.evttag[11:0]), 88'd0);

        // Asynchronous reset with tags queued.
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        repeat (5) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("t6_pre_occ", 88'(bus.occupancy), 88'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_zero();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("t6_post_valid", 88'(bus.evttag_valid), 88'd1);
        check("t6_post_evtid", 88'(bus.evttag[87:56]), 88'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
